opb_register_bank_simulink2ppc: RTL and testbench

Parametrised successor to the single software register. Exposes C_NUM_REGS user-side 32-bit status words to the PowerPC over OPB. Adds an atomic multi-word snapshot, a software freeze control and an update counter. User data arrives already synchronous to OPB_Clk; any clock-domain crossing is done upstream.

---
 rtl/opb_reg_bank_pkg.sv | 23 ++
 rtl/opb_slave_ack_fsm.sv | 96 +++++++++
 rtl/opb_register_bank_simulink2ppc.sv | 111 +++++++++++
 tb/tb_opb_register_bank_simulink2ppc.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_reg_bank_pkg.sv
// Shared types and constants for the OPB register bank: FSM states, CTRL layout
// and the index-width helper.
package opb_reg_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int CTRL_FREEZE_BIT = 31;
  localparam int CNT_W           = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// OPB slave decode and handshake: one xferAck per select assertion, with the
// decoded word index and transfer attributes held stable through the ACK cycle.
module opb_slave_ack_fsm
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'h01020200,
  parameter logic [31:0] C_HIGHADDR = 32'h010202FF,
  parameter int          C_NUM_REGS = 4,
  parameter int          IDX_W      = clog2(C_NUM_REGS + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      abus,
  input  logic             select,
  input  logic             rnw_in,
  input  logic [0:31]      dbus,
  input  logic [0:3]       be_in,
  output logic             xfer_ack,
  output logic             err_ack,
  output logic             acc,
  output logic             snap_req,
  output logic [IDX_W-1:0] idx,
  output logic             rnw,
  output logic [0:31]      wdata,
  output logic [0:3]       be,
  output state_t           state
);

  // Index encoding: 0..N-1 data words, N = CTRL, N+1 = anything unmapped.
  localparam logic [31:0]      NUM_W     = 32'(C_NUM_REGS);
  localparam logic [IDX_W-1:0] CTRL_IDX  = IDX_W'(C_NUM_REGS);
  localparam logic [IDX_W-1:0] UNMAP_IDX = IDX_W'(C_NUM_REGS + 1);

  logic [31:0]      offset;
  logic [31:0]      word;
  logic             hit;
  logic [IDX_W-1:0] idx_dec;
  logic             xfer_q;
  logic             err_q;

  assign offset = abus - C_BASEADDR;
  assign word   = offset >> 2;
  assign hit    = select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);

  always_comb begin
    idx_dec = UNMAP_IDX;
    if (word < NUM_W)       idx_dec = word[IDX_W-1:0];
    else if (word == NUM_W) idx_dec = CTRL_IDX;
  end

  // Snapshot capture must happen on the accepting edge, so it is combinational.
  assign snap_req = (state == IDLE) && hit && rnw_in && (idx_dec == '0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      xfer_q <= 1'b0;
      err_q  <= 1'b0;
      idx    <= '0;
      rnw    <= 1'b0;
      wdata  <= '0;
      be     <= '0;
    end else begin
      case (state)
        IDLE: begin
          xfer_q <= 1'b0;
          err_q  <= 1'b0;
          if (hit) begin
            idx    <= idx_dec;
            rnw    <= rnw_in;
            wdata  <= dbus;
            be     <= be_in;
            xfer_q <= 1'b1;
            err_q  <= (idx_dec == UNMAP_IDX) || (!rnw_in && (idx_dec < CTRL_IDX));
            state  <= ACK;
          end
        end
        ACK: begin
          xfer_q <= 1'b0;
          err_q  <= 1'b0;
          state  <= HOLD;
        end
        HOLD: begin
          if (!select) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset arriving during ACK abandons the transfer without an acknowledge.
  assign xfer_ack = xfer_q && !rst;
  assign err_ack  = err_q && !rst;
  assign acc      = xfer_ack;

endmodule

// File: rtl/opb_register_bank_simulink2ppc.sv
// Bank of user-side status words readable over OPB, with atomic snapshot via
// word 0, a software freeze bit and a 16-bit update counter in the CTRL word.
module opb_register_bank_simulink2ppc
  import opb_reg_bank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h01020200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010202FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter int          C_SNAPSHOT   = 1,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst,
  output logic [0:C_OPB_DWIDTH-1]   Sl_DBus,
  output logic                      Sl_errAck,
  output logic                      Sl_retry,
  output logic                      Sl_toutSup,
  output logic                      Sl_xferAck,
  input  logic [0:C_OPB_AWIDTH-1]   OPB_ABus,
  input  logic [0:3]                OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_RNW,
  input  logic                      OPB_select,
  input  logic                      OPB_seqAddr,
  input  logic [32*C_NUM_REGS-1:0]  user_data_in,
  input  logic                      user_valid
);

  localparam int               IDX_W    = clog2(C_NUM_REGS + 2);
  localparam logic [IDX_W-1:0] CTRL_IDX = IDX_W'(C_NUM_REGS);

  logic             acc;
  logic             snap_req;
  logic             rnw;
  logic [IDX_W-1:0] idx;
  logic [0:31]      wdata;
  logic [0:3]       be;
  state_t           fsm_state;

  logic [31:0]      shadow [C_NUM_REGS];
  logic [31:0]      held   [C_NUM_REGS];
  logic [CNT_W-1:0] update_count;
  logic             freeze;
  logic [31:0]      rdata;
  logic             unused_ok;

  opb_slave_ack_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR),
    .C_NUM_REGS (C_NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_fsm (
    .clk      (OPB_Clk),
    .rst      (OPB_Rst),
    .abus     (OPB_ABus),
    .select   (OPB_select),
    .rnw_in   (OPB_RNW),
    .dbus     (OPB_DBus),
    .be_in    (OPB_BE),
    .xfer_ack (Sl_xferAck),
    .err_ack  (Sl_errAck),
    .acc      (acc),
    .snap_req (snap_req),
    .idx      (idx),
    .rnw      (rnw),
    .wdata    (wdata),
    .be       (be),
    .state    (fsm_state)
  );

  // Capture reads the pre-update shadows when user_valid coincides with it.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        shadow[i] <= '0;
        held[i]   <= '0;
      end
      update_count <= '0;
      freeze       <= 1'b0;
    end else begin
      if (user_valid && !freeze) begin
        for (int i = 0; i < C_NUM_REGS; i++) shadow[i] <= user_data_in[32*i +: 32];
        update_count <= update_count + 1'b1;
      end
      if (snap_req) begin
        for (int i = 0; i < C_NUM_REGS; i++) held[i] <= shadow[i];
      end
      if (acc && !rnw && (idx == CTRL_IDX) && be[3]) freeze <= wdata[CTRL_FREEZE_BIT];
    end
  end

  always_comb begin
    rdata = '0;
    if (idx == CTRL_IDX) begin
      rdata = {update_count, {(31 - CNT_W){1'b0}}, freeze};
    end else begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (idx == IDX_W'(i)) rdata = (C_SNAPSHOT != 0) ? held[i] : shadow[i];
      end
    end
  end

  assign Sl_DBus    = ((fsm_state == ACK) && rnw && !OPB_Rst) ? rdata : '0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_ok = ^{OPB_seqAddr, wdata[0:30], be[0:2]};

endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Directed and randomized checks of the OPB register bank against a
// transaction-level model of shadows, snapshot, freeze and update counter.
module tb_opb_register_bank_simulink2ppc;

  localparam logic [31:0] BASE = 32'h01020200;
  localparam logic [31:0] HIGH = 32'h010202FF;
  localparam int          N    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [0:31]      abus;
  logic [0:31]      dbus_w;
  logic [0:3]       be;
  logic             rnw;
  logic             select;
  logic             seq_addr;
  logic             user_valid;
  logic [32*N-1:0]  user_data;
  logic [0:31]      sl_dbus;
  logic             sl_err;
  logic             sl_retry;
  logic             sl_tout;
  logic             sl_ack;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_shadow [N];
  logic [31:0] m_held   [N];
  logic [15:0] m_count;
  logic        m_freeze;

  always #5 clk = ~clk;

  opb_register_bank_simulink2ppc dut (
    .OPB_Clk      (clk),
    .OPB_Rst      (rst),
    .Sl_DBus      (sl_dbus),
    .Sl_errAck    (sl_err),
    .Sl_retry     (sl_retry),
    .Sl_toutSup   (sl_tout),
    .Sl_xferAck   (sl_ack),
    .OPB_ABus     (abus),
    .OPB_BE       (be),
    .OPB_DBus     (dbus_w),
    .OPB_RNW      (rnw),
    .OPB_select   (select),
    .OPB_seqAddr  (seq_addr),
    .user_data_in (user_data),
    .user_valid   (user_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0;
      m_held[i]   = '0;
    end
    m_count  = '0;
    m_freeze = 1'b0;
  endtask

  task automatic model_update(input logic uv, input logic [32*N-1:0] ud);
    if (uv && !m_freeze) begin
      for (int i = 0; i < N; i++) m_shadow[i] = ud[32*i +: 32];
      m_count = m_count + 16'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    select     = 1'b0;
    user_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.dbus", sl_dbus, 32'h0);
    check("reset.ack", sl_ack, 32'h0);
    check("reset.err", sl_err, 32'h0);
    rst = 1'b0;
    model_reset();
  endtask

  // One full select cycle: accept, ACK sampled at n+1, ack gone the cycle after.
  task automatic do_access(input string tag, input logic [31:0] addr, input logic r,
                           input logic [31:0] wd, input logic [0:3] b,
                           input logic uv, input logic [32*N-1:0] ud);
    int          w;
    logic [31:0] exp_d;
    logic        exp_e;
    @(negedge clk);
    abus       = addr;
    rnw        = r;
    dbus_w     = wd;
    be         = b;
    select     = 1'b1;
    user_valid = uv;
    user_data  = ud;
    w     = int'((addr - BASE) >> 2);
    exp_d = '0;
    exp_e = 1'b0;
    if (w < N) begin
      if (r) begin
        if (w == 0) for (int i = 0; i < N; i++) m_held[i] = m_shadow[i];
        exp_d = m_held[w];
      end else begin
        exp_e = 1'b1;
      end
    end else if (w > N) begin
      exp_e = 1'b1;
    end
    model_update(uv, ud);
    if (w == N && r) exp_d = {m_count, 15'd0, m_freeze};
    @(negedge clk);
    user_valid = 1'b0;
    check({tag, ".ack"}, sl_ack, 32'h1);
    check({tag, ".err"}, sl_err, exp_e);
    check({tag, ".data"}, sl_dbus, exp_d);
    select = 1'b0;
    if (w == N && !r && b[3]) m_freeze = wd[0];
    @(negedge clk);
    check({tag, ".ack_drop"}, sl_ack, 32'h0);
  endtask

  task automatic pulse_uv(input logic [32*N-1:0] ud, input int n);
    @(negedge clk);
    user_data  = ud;
    user_valid = 1'b1;
    for (int k = 0; k < n; k++) begin
      model_update(1'b1, ud);
      @(negedge clk);
    end
    user_valid = 1'b0;
  endtask

  task automatic count_acks(input string tag, input logic [31:0] addr, input int cycles, input int exp_acks);
    int acks;
    acks = 0;
    @(negedge clk);
    abus   = addr;
    rnw    = 1'b1;
    select = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      acks += int'(sl_ack);
    end
    select = 1'b0;
    check(tag, acks, exp_acks);
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [32*N-1:0] rand_words();
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [32*N-1:0] d;
    logic [32*N-1:0] none;
    none       = '0;
    rst        = 1'b1;
    abus       = '0;
    dbus_w     = '0;
    be         = '0;
    rnw        = 1'b1;
    select     = 1'b0;
    seq_addr   = 1'b0;
    user_valid = 1'b0;
    user_data  = '0;
    model_reset();

    do_reset();
    check("tied.retry", sl_retry, 32'h0);
    check("tied.tout", sl_tout, 32'h0);
    do_access("ctrl_rd0", BASE + 4*N, 1'b1, 0, 4'b1111, 1'b0, none);

    d = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    pulse_uv(d, 1);
    for (int i = 0; i < N; i++) do_access($sformatf("word_rd%0d", i), BASE + 4*i, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("ctrl_rd1", BASE + 4*N, 1'b1, 0, 4'b1111, 1'b0, none);

    do_access("snap_rd0", BASE, 1'b1, 0, 4'b1111, 1'b0, none);
    pulse_uv({4{32'hAAAAAAAA}}, 1);
    do_access("snap_rd2_old", BASE + 8, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("snap_rd0_new", BASE, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("snap_rd2_new", BASE + 8, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("snap_same_cycle", BASE, 1'b1, 0, 4'b1111, 1'b1, {4{32'h5A5A5A5A}});
    do_access("snap_after_uv", BASE, 1'b1, 0, 4'b1111, 1'b0, none);

    do_access("freeze_wr", BASE + 4*N, 1'b0, 32'h1, 4'b0001, 1'b0, none);
    for (int k = 0; k < 3; k++) pulse_uv(rand_words(), 1);
    do_access("freeze_ctrl", BASE + 4*N, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("freeze_rd0", BASE, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("freeze_be_ign", BASE + 4*N, 1'b0, 32'h0, 4'b1110, 1'b0, none);
    do_access("freeze_ctrl2", BASE + 4*N, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("unfreeze", BASE + 4*N, 1'b0, 32'h0, 4'b0001, 1'b0, none);

    do_access("err_wr_data", BASE + 4, 1'b0, 32'hDEADBEEF, 4'b1111, 1'b0, none);
    do_access("err_rd0", BASE, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("err_rd1", BASE + 4, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("err_unmapped", BASE + 32'h40, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("err_top_word", HIGH - 3, 1'b1, 0, 4'b1111, 1'b0, none);
    count_acks("hold5.acks", BASE + 4*N, 5, 1);
    count_acks("above_high.acks", HIGH + 1, 3, 0);
    count_acks("below_base.acks", BASE - 4, 3, 0);

    for (int it = 0; it < 150; it++) begin
      int          kind;
      int          w;
      logic        uv;
      logic [31:0] addr;
      kind = $urandom_range(0, 9);
      uv   = ($urandom_range(0, 3) == 0);
      d    = rand_words();
      w    = $urandom_range(0, N - 1);
      addr = BASE + 4*w + $urandom_range(0, 3);
      case (kind)
        0, 1:       pulse_uv(d, $urandom_range(1, 3));
        2, 3, 4, 5: do_access("rnd_rd", addr, 1'b1, 0, 4'b1111, uv, d);
        6:          do_access("rnd_ctrl_rd", BASE + 4*N, 1'b1, 0, 4'b1111, uv, d);
        7:          do_access("rnd_ctrl_wr", BASE + 4*N, 1'b0, $urandom(), 4'($urandom_range(0, 15)), uv, d);
        8:          do_access("rnd_unmapped", BASE + 4*$urandom_range(N + 1, 63), $urandom_range(0, 1) == 1, $urandom(), 4'b1111, uv, d);
        default:    do_access("rnd_wr_data", addr, 1'b0, $urandom(), 4'b1111, uv, d);
      endcase
    end

    do_reset();
    pulse_uv({4{32'h0F0F0F0F}}, 65535);
    do_access("wrap_ffff", BASE + 4*N, 1'b1, 0, 4'b1111, 1'b0, none);
    pulse_uv({4{32'hF0F0F0F0}}, 1);
    do_access("wrap_zero", BASE + 4*N, 1'b1, 0, 4'b1111, 1'b0, none);

    do_access("pre_rst_rd0", BASE, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("pre_rst_frz", BASE + 4*N, 1'b0, 32'h1, 4'b0001, 1'b0, none);
    @(negedge clk);
    abus   = BASE + 4*N;
    rnw    = 1'b1;
    select = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid.ack", sl_ack, 32'h0);
    check("rst_mid.err", sl_err, 32'h0);
    check("rst_mid.dbus", sl_dbus, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_retry.ack", sl_ack, 32'h1);
    check("rst_retry.data", sl_dbus, 32'h0);
    check("rst_retry.err", sl_err, 32'h0);
    select = 1'b0;
    @(negedge clk);
    check("rst_retry.ack_drop", sl_ack, 32'h0);
    do_access("post_rst_rd1", BASE + 4, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("post_rst_rd0", BASE, 1'b1, 0, 4'b1111, 1'b0, none);
    do_access("post_rst_ctrl", BASE + 4*N, 1'b1, 0, 4'b1111, 1'b0, none);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
